mult_div_unit: RTL

//  Iterative HI/LO multiply/divide unit for the MIPS core: MULT, MULTU, DIV, DIVU, MTHI, MTLO.

---
 rtl/mips_md_pkg.sv | 28 ++
 rtl/mult_div_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mips_md_pkg.sv
// Shared types and opcode helpers for the HI/LO multiply/divide unit.
package mips_md_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL   = 2'd1,
      ST_DIV   = 2'd2,
      ST_FIXUP = 2'd3
   } md_state_t;

   function automatic logic is_signed_op(md_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic is_div_op(md_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes up front; signs are reapplied in FIXUP.
module mult_div_unit
   import mips_md_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter bit          FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned W2 = 2 * WIDTH;

   md_state_t        state;
   logic [CW-1:0]    cnt;
   logic [W2-1:0]    acc;
   logic [WIDTH-1:0] opb;
   logic             neg_lo;
   logic             neg_hi;
   logic             is_div;

   logic             a_neg_c;
   logic             b_neg_c;
   logic [WIDTH-1:0] mag_a_c;
   logic [WIDTH-1:0] mag_b_c;
   logic [WIDTH:0]   add_c;
   logic [WIDTH:0]   shl_c;
   logic [WIDTH:0]   sub_c;
   logic             div_ge_c;
   logic [W2-1:0]    prod_c;
   logic [W2-1:0]    prod_fix_c;
   logic [WIDTH-1:0] quo_fix_c;
   logic [WIDTH-1:0] rem_fix_c;

   // Operand magnitudes; only signed ops look at the sign bits.
   always_comb begin
      a_neg_c = is_signed_op(op) & a[WIDTH-1];
      b_neg_c = is_signed_op(op) & b[WIDTH-1];
      mag_a_c = a_neg_c ? -a : a;
      mag_b_c = b_neg_c ? -b : b;
   end

   // Shared per-bit datapath: acc = {upper/remainder, multiplier/quotient}.
   always_comb begin
      add_c    = {1'b0, acc[W2-1:WIDTH]} + {1'b0, opb & {WIDTH{acc[0]}}};
      shl_c    = {acc[W2-1:WIDTH], acc[WIDTH-1]};
      sub_c    = shl_c - {1'b0, opb};
      div_ge_c = ~sub_c[WIDTH];
   end

   if (FAST_MUL) begin : g_fast_mul
      assign prod_c = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, opb};
   end else begin : g_iter_mul
      assign prod_c = acc;
   end

   always_comb begin
      prod_fix_c = neg_lo ? -prod_c : prod_c;
      quo_fix_c  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix_c  = neg_hi ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         acc         <= '0;
         opb         <= '0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         is_div      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !cancel) begin
                  case (op)
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     MD_MULT, MD_MULTU: begin
                        acc    <= {{WIDTH{1'b0}}, mag_a_c};
                        opb    <= mag_b_c;
                        neg_lo <= a_neg_c ^ b_neg_c;
                        neg_hi <= 1'b0;
                        is_div <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= FAST_MUL ? ST_FIXUP : ST_MUL;
                     end
                     MD_DIV, MD_DIVU: begin
                        if (b == '0) begin
                           done        <= 1'b1;
                           div_by_zero <= 1'b1;
                        end else begin
                           acc    <= {{WIDTH{1'b0}}, mag_a_c};
                           opb    <= mag_b_c;
                           neg_lo <= a_neg_c ^ b_neg_c;
                           neg_hi <= a_neg_c;
                           is_div <= 1'b1;
                           cnt    <= '0;
                           busy   <= 1'b1;
                           state  <= ST_DIV;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (cancel) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc <= {add_c, acc[WIDTH-1:1]};
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) state <= ST_FIXUP;
               end
            end
            ST_DIV: begin
               if (cancel) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc <= {(div_ge_c ? sub_c[WIDTH-1:0] : shl_c[WIDTH-1:0]),
                          acc[WIDTH-2:0], div_ge_c};
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(WIDTH - 1)) state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
               if (!cancel) begin
                  done <= 1'b1;
                  if (is_div) begin
                     lo <= quo_fix_c;
                     hi <= rem_fix_c;
                  end else begin
                     {hi, lo} <= prod_fix_c;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
